// File: rtl/stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : stream_checker
// Purpose  : Receive-side stream checker. It delays the reference stream by
//            LATENCY cycles and compares it word-by-word against the stream
//            under test over a window of CHECK_LEN words. It counts matches
//            and mismatches, records the index of the first mismatch, and
//            reports pass/fail with a one-cycle done pulse.
// Options  : define STREAM_CHECKER_ERR_CAPTURE_EN to latch the expected and
//            actual words of the first mismatch on first_exp / first_act.
//            When the macro is undefined, those ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module stream_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 1,
  parameter int CHECK_LEN  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ref_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_exp,
  output logic [DATA_WIDTH-1:0] first_act
);

  // Out-of-range parameters are clamped to the legal range rather than
  // producing a broken build (e.g. CHECK_LEN=70000 runs 65535 compares).
  localparam int LAT_C = (LATENCY < 1)  ? 1  :
                         (LATENCY > 32) ? 32 : LATENCY;
  localparam int CHK_C = (CHECK_LEN < 1)     ? 1     :
                         (CHECK_LEN > 65535) ? 65535 : CHECK_LEN;

  localparam logic [4:0]  FILL_LOAD = 5'(LAT_C - 1);
  localparam logic [15:0] LAST_IDX  = 16'(CHK_C - 1);

  // The compare index is 16 bits wide; widen it when the counters are wider
  // so the index can be range-checked against the counter width.
  localparam int IDX_W = (CNT_WIDTH > 16) ? CNT_WIDTH : 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [4:0]            fill_cnt;
  logic [15:0]           cmp_idx;
  logic [DATA_WIDTH-1:0] dly [LAT_C];
  logic [DATA_WIDTH-1:0] exp_word;
  logic [IDX_W-1:0]      idx_ext;
  logic                  idx_fits;
  logic                  accept;
  logic                  in_check;
  logic                  fill_zero;
  logic                  last_cmp;
  logic                  mismatch;

  // ---------------------------------------------------------------------------
  // Reference delay line. It shifts in every state so that it is already
  // primed with valid history when a run starts.
  // ---------------------------------------------------------------------------

  // First stage captures the raw reference word.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      dly[0] <= '0;
    end else begin
      dly[0] <= ref_in;
    end
  end

  generate
    for (genvar i = 1; i < LAT_C; i++) begin : g_dly_stage
      // Each further stage adds one cycle of delay.
      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          dly[i] <= '0;
        end else begin
          dly[i] <= dly[i-1];
        end
      end
    end
  endgenerate

  assign exp_word = dly[LAT_C-1];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign accept    = (state == S_IDLE) && start;
  assign in_check  = (state == S_CHECK);
  assign fill_zero = (fill_cnt == 5'd0);
  assign last_cmp  = in_check && (cmp_idx == LAST_IDX);

  // A 4-state inequality counts X/Z on data_in as a mismatch in simulation;
  // synthesis treats this as an ordinary inequality.
  assign mismatch  = (data_in !== exp_word);

  // The first-error index saturates to all-ones if it cannot fit the counter.
  assign idx_ext   = IDX_W'(cmp_idx);
  assign idx_fits  = ((idx_ext >> CNT_WIDTH) == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------

  // State register; reset has priority over a same-cycle start.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_FILL;
      S_FILL:  if (fill_zero) state_nxt = S_CHECK;
      S_CHECK: if (last_cmp)  state_nxt = S_DONE;
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: busy spans FILL and CHECK, done is the single DONE cycle.
  always_comb begin
    busy = (state == S_FILL) || (state == S_CHECK);
    done = (state == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: fill counter, compare index, result counters and verdict
  // ---------------------------------------------------------------------------

  // Counters clear on an accepted start and hold after DONE until the next one.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      fill_cnt      <= '0;
      cmp_idx       <= '0;
      err_count     <= '0;
      match_count   <= '0;
      first_err_idx <= '1;
      pass          <= 1'b0;
    end else if (accept) begin
      fill_cnt      <= FILL_LOAD;
      cmp_idx       <= '0;
      err_count     <= '0;
      match_count   <= '0;
      first_err_idx <= '1;
      pass          <= 1'b0;
    end else begin
      if ((state == S_FILL) && !fill_zero) begin
        fill_cnt <= fill_cnt - 5'd1;
      end
      if (in_check) begin
        // LAST_IDX is at most 65534, so the index never wraps.
        cmp_idx <= cmp_idx + 16'd1;
        if (mismatch) begin
          if (err_count != '1) begin
            err_count <= err_count + CNT_WIDTH'(1);
          end
          if (err_count == '0) begin
            first_err_idx <= idx_fits ? CNT_WIDTH'(idx_ext) : '1;
          end
        end else if (match_count != '1) begin
          match_count <= match_count + CNT_WIDTH'(1);
        end
        // The verdict is registered on the last compare so it is valid
        // in the same cycle as the done pulse.
        if (last_cmp) begin
          pass <= (err_count == '0) && !mismatch;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional first-mismatch capture
  // ---------------------------------------------------------------------------
`ifdef STREAM_CHECKER_ERR_CAPTURE_EN
  // Latch the expected and actual words of the first mismatch of a run.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      first_exp <= '0;
      first_act <= '0;
    end else if (accept) begin
      first_exp <= '0;
      first_act <= '0;
    end else if (in_check && mismatch && (err_count == '0)) begin
      first_exp <= exp_word;
      first_act <= data_in;
    end
  end
`else
  assign first_exp = '0;
  assign first_act = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_checker
// Purpose  : Scoreboard bench for stream_checker. Four instances cover the
//            identity path, a 3-stage core with a matching checker, a
//            mismatched checker latency, and the saturating long run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_checker;

  localparam int DW = 8;
  localparam int CW = 16;
`ifdef STREAM_CHECKER_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        pass;
    logic [15:0] err;
    logic [15:0] mat;
    logic [15:0] idx;
    logic [7:0]  fe;
    logic [7:0]  fa;
    int unsigned at;
  } exp_t;

  logic          clk = 1'b0;
  int unsigned   cyc = 0;
  logic [3:0]    rst_n;
  logic [3:0]    start;
  logic [DW-1:0] ref_in;
  logic          force_err;
  logic [DW-1:0] core1, c3_a, c3_b, c3_c;
  logic [DW-1:0] data_a;

  logic [3:0]    busy, done, pass;
  logic [CW-1:0] err_c [4];
  logic [CW-1:0] mat_c [4];
  logic [CW-1:0] idx_c [4];
  logic [DW-1:0] fexp  [4];
  logic [DW-1:0] fact  [4];

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Cycle counter: number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Core models: a 1-stage and a 3-stage register pipeline on ref_in.
  always @(posedge clk) begin
    core1 <= ref_in;
    c3_a  <= ref_in;
    c3_b  <= c3_a;
    c3_c  <= c3_b;
  end

  assign data_a = force_err ? 8'hA5 : core1;

  stream_checker #(.DATA_WIDTH(DW), .LATENCY(1), .CHECK_LEN(16), .CNT_WIDTH(CW)) u_a (
    .Clk(clk), .Rst_n(rst_n[0]), .start(start[0]), .ref_in(ref_in), .data_in(data_a),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_c[0]),
    .match_count(mat_c[0]), .first_err_idx(idx_c[0]), .first_exp(fexp[0]), .first_act(fact[0]));

  stream_checker #(.DATA_WIDTH(DW), .LATENCY(3), .CHECK_LEN(16), .CNT_WIDTH(CW)) u_b (
    .Clk(clk), .Rst_n(rst_n[1]), .start(start[1]), .ref_in(ref_in), .data_in(c3_c),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_c[1]),
    .match_count(mat_c[1]), .first_err_idx(idx_c[1]), .first_exp(fexp[1]), .first_act(fact[1]));

  stream_checker #(.DATA_WIDTH(DW), .LATENCY(2), .CHECK_LEN(16), .CNT_WIDTH(CW)) u_c (
    .Clk(clk), .Rst_n(rst_n[2]), .start(start[2]), .ref_in(ref_in), .data_in(c3_c),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err_c[2]),
    .match_count(mat_c[2]), .first_err_idx(idx_c[2]), .first_exp(fexp[2]), .first_act(fact[2]));

  stream_checker #(.DATA_WIDTH(DW), .LATENCY(1), .CHECK_LEN(70000), .CNT_WIDTH(CW)) u_d (
    .Clk(clk), .Rst_n(rst_n[3]), .start(start[3]), .ref_in(8'h00), .data_in(8'hFF),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(err_c[3]),
    .match_count(mat_c[3]), .first_err_idx(idx_c[3]), .first_exp(fexp[3]), .first_act(fact[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int id, input logic p, input logic [15:0] er,
                              input logic [15:0] ma, input logic [15:0] ix,
                              input logic [7:0] fe, input logic [7:0] fa);
    exp_t e;
    e.id = id; e.pass = p; e.err = er; e.mat = ma; e.idx = ix;
    e.fe = CAP ? fe : 8'h00;
    e.fa = CAP ? fa : 8'h00;
    e.at = 0;
    return e;
  endfunction

  // Advance to the next falling edge; the reference stream counts up by one.
  task automatic tick();
    @(negedge clk);
    ref_in = ref_in + 8'd1;
  endtask

  // Pulse start so that ref_in is 0xFF in the start cycle; the first compared
  // word (ref_in of the following cycle) is then 0x00, so compare k expects k.
  task automatic launch(input int d, input int lat, input int len, input bit push, input exp_t e);
    exp_t x;
    while (ref_in != 8'hFF) tick();
    start[d] = 1'b1;
    if (push) begin
      x    = e;
      x.at = cyc + 1 + lat + len;
      sb.push_back(x);
    end
    tick();
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL run_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every done pulse pops the oldest expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (done[d]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: dut %0d done=1, expected 0", d);
          end else begin
            e = sb.pop_front();
            chk("done_dut",      d,         e.id);
            chk("done_cycle",    cyc,       e.at);
            chk("pass",          pass[d],   e.pass);
            chk("err_count",     err_c[d],  e.err);
            chk("match_count",   mat_c[d],  e.mat);
            chk("first_err_idx", idx_c[d],  e.idx);
            chk("first_exp",     fexp[d],   e.fe);
            chk("first_act",     fact[d],   e.fa);
            chk("busy_at_done",  busy[d],   1'b0);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 4'h0; start = 4'h0; ref_in = 8'h00; force_err = 1'b0;
    repeat (3) tick();

    // Reset values on every instance.
    for (int d = 0; d < 4; d++) begin
      chk("rst_busy", busy[d], 1'b0);
      chk("rst_done", done[d], 1'b0);
      chk("rst_pass", pass[d], 1'b0);
      chk("rst_err",  err_c[d], 16'h0000);
      chk("rst_mat",  mat_c[d], 16'h0000);
      chk("rst_idx",  idx_c[d], 16'hFFFF);
      chk("rst_fexp", fexp[d], 8'h00);
      chk("rst_fact", fact[d], 8'h00);
    end
    rst_n = 4'hF;
    tick();

    // Start in the same cycle as reset: reset wins, no run begins.
    rst_n[0] = 1'b0; start[0] = 1'b1;
    tick();
    rst_n[0] = 1'b1; start[0] = 1'b0;
    chk("start_under_reset_busy", busy[0], 1'b0);
    repeat (3) tick();
    chk("start_under_reset_idle", busy[0], 1'b0);

    // Identity path, clean run.
    launch(0, 1, 16, 1'b1, mk(0, 1'b1, 16'd0, 16'd16, 16'hFFFF, 8'h00, 8'h00));
    chk("busy_after_start", busy[0], 1'b1);
    wait_done(40);

    // Single corrupted word at compare index 3 (expected word 0x03).
    launch(0, 1, 16, 1'b1, mk(0, 1'b0, 16'd1, 16'd15, 16'd3, 8'h03, 8'hA5));
    repeat (4) tick();
    force_err = 1'b1;
    tick();
    force_err = 1'b0;
    wait_done(40);
    repeat (3) tick();
    chk("hold_err_after_done",  err_c[0], 16'd1);
    chk("hold_pass_after_done", pass[0], 1'b0);

    // 3-stage core with matching checker latency.
    launch(1, 3, 16, 1'b1, mk(1, 1'b1, 16'd0, 16'd16, 16'hFFFF, 8'h00, 8'h00));
    wait_done(40);

    // Same core, checker latency 2: every word is off by one.
    launch(2, 2, 16, 1'b1, mk(2, 1'b0, 16'd16, 16'd0, 16'd0, 8'h00, 8'hFF));
    wait_done(40);

    // Second start at compare index 5 is ignored; done stays on schedule.
    launch(0, 1, 16, 1'b1, mk(0, 1'b1, 16'd0, 16'd16, 16'hFFFF, 8'h00, 8'h00));
    repeat (6) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("busy_after_restart", busy[0], 1'b1);
    wait_done(40);

    // Reset for one cycle at compare index 8: abort with no done pulse.
    launch(0, 1, 16, 1'b0, mk(0, 1'b0, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00));
    repeat (9) tick();
    chk("matches_before_abort", mat_c[0], 16'd8);
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    chk("abort_err",  err_c[0], 16'd0);
    chk("abort_mat",  mat_c[0], 16'd0);
    chk("abort_idx",  idx_c[0], 16'hFFFF);
    chk("abort_pass", pass[0], 1'b0);
    repeat (30) tick();
    launch(0, 1, 16, 1'b1, mk(0, 1'b1, 16'd0, 16'd16, 16'hFFFF, 8'h00, 8'h00));
    wait_done(40);

    // Oversized CHECK_LEN clamps to 65535; every compare fails.
    launch(3, 1, 65535, 1'b1, mk(3, 1'b0, 16'hFFFF, 16'd0, 16'd0, 8'h00, 8'hFF));
    wait_done(65600);
    repeat (3) tick();
    chk("sat_err_hold", err_c[3], 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
